// File: rtl/gpio_tick_ctrl.sv
// rtl/gpio_tick_ctrl.sv - run/step/fast clock-enable generator with GPIO latch and tick counter
module gpio_tick_ctrl #(
  parameter int DIV_W     = 26,
  parameter int GPIO_W    = 8,
  parameter int DB_CYCLES = 1000000
) (
  input  logic              mclk,
  input  logic              Resetn,
  input  logic [1:0]        mode_i,
  input  logic              step_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic              tick_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [15:0]       tick_cnt_o,
  output logic [1:0]        state_o
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_FAST = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [GPIO_W-1:0]   gpio_q;
  logic [15:0]         tick_cnt_q;
  logic                sync1_q, sync2_q;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                db_lvl_q, db_lvl_d;
  logic                db_rise;

  always_ff @(posedge mclk or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= step_i;
      sync2_q <= sync1_q;
    end
  end

  // Level flips only after DB_CYCLES consecutive disagreeing samples; any agreement restarts.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    db_rise  = 1'b0;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d = sync2_q;
        db_rise  = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge mclk or negedge Resetn) begin
    if (!Resetn) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  always_ff @(posedge mclk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_HALT;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_e'(mode_i);
    cnt_d   = '0;
    tick_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (cnt_q >= div_i) begin
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_STEP:  tick_d = db_rise;
      S_FAST:  tick_d = 1'b1;
      default: tick_d = 1'b0;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // The core consumes gpio_i at the edge where its clock enable is high.
  always_ff @(posedge mclk or negedge Resetn) begin
    if (!Resetn) begin
      gpio_q     <= '0;
      tick_cnt_q <= '0;
    end else if (tick_q) begin
      gpio_q     <= gpio_i;
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  assign tick_o     = tick_q;
  assign gpio_o     = gpio_q;
  assign tick_cnt_o = tick_cnt_q;
  assign state_o    = state_q;

endmodule

// File: doc/gpio_tick_ctrl.md
GPIO_TICK_CTRL -- requirements
Module: gpio_tick_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 26, width of divider terminal count.
REQ-002 SHALL have parameter GPIO_W, default 8, number of GPIO output channels.
REQ-003 SHALL have parameter DB_CYCLES, default 1000000, debounce stability window in mclk cycles.
REQ-004 SHALL have port mclk  input  1  sole clock, rising-edge.
REQ-005 SHALL have port Resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mode_i  input  2  00 HALT, 01 RUN, 10 STEP, 11 FAST.
REQ-007 SHALL have port step_i  input  1  raw asynchronous push-button, active-high.
REQ-008 SHALL have port div_i  input  DIV_W  divider terminal count for RUN.
REQ-009 SHALL have port gpio_i  input  GPIO_W  core GPIO value.
REQ-010 SHALL have port tick_o  output  1  single-cycle clock enable to the core.
REQ-011 SHALL have port gpio_o  output  GPIO_W  GPIO latched on tick, drives LEDs.
REQ-012 SHALL have port tick_cnt_o  output  16  count of ticks issued.
REQ-013 SHALL have port state_o  output  2  current FSM state encoding.

Function
REQ-014 SHALL implement FSM states S_HALT=00, S_RUN=01, S_STEP=10, S_FAST=11; state_o equals the state register.
REQ-015 SHALL load the state from mode_i every cycle; the new mode takes effect on the cycle after mode_i changes.
REQ-016 SHALL clear the divider counter to 0 on the cycle the state changes.
REQ-017 S_HALT: divider held at 0, tick_o=0.
REQ-018 S_RUN: divider increments each cycle; when cnt >= div_i, tick_o=1 for that cycle and cnt returns to 0; period = div_i+1 cycles.
REQ-019 S_RUN with div_i=0 SHALL produce tick_o=1 every cycle.
REQ-020 If div_i is lowered below the current cnt mid-count, the tick SHALL fire on the next cycle (>= compare) and wrap to 0; no counter overrun.
REQ-021 S_FAST: tick_o=1 every cycle regardless of div_i.
REQ-022 step_i SHALL pass a 2-flop synchroniser before any use.
REQ-023 The debounced step level SHALL change only after the synchronised input differs from it for DB_CYCLES consecutive cycles; any mismatch reversal restarts the window.
REQ-024 S_STEP: exactly one tick_o pulse per rising edge of the debounced step level; holding the button produces no further ticks.
REQ-025 A debounced rising edge occurring outside S_STEP SHALL be discarded, not queued.
REQ-026 tick_o SHALL be a registered output, never wider than one cycle per event.
REQ-027 gpio_o SHALL capture gpio_i on the clock edge at which tick_o=1; otherwise gpio_o holds.
REQ-028 tick_cnt_o SHALL increment by 1 per tick_o pulse and wrap 0xFFFF -> 0x0000.

Reset
REQ-029 Resetn=0 SHALL asynchronously force state S_HALT, divider 0, synchroniser flops 0, debounce counter 0, debounced level 0, tick_o=0, gpio_o=0, tick_cnt_o=0, state_o=00.
REQ-030 Reset asserted mid-count or mid-debounce SHALL abandon the operation; no tick issued on release.
REQ-031 After Resetn deassertion the first possible tick SHALL be no earlier than the second rising edge of mclk.

Verification
REQ-032 RUN, div_i=4, gpio_i=0xA5 -> tick_o pulses every 5 cycles, gpio_o=0xA5 after first tick, tick_cnt_o=3 after 15 cycles.
REQ-033 RUN, div_i=9, at cnt=7 set div_i=3 -> tick on next cycle, then period 4.
REQ-034 STEP, DB_CYCLES=4, step_i bouncing 1-0-1 within 3 cycles then held high 20 cycles -> exactly one tick_o pulse, tick_cnt_o=1.
REQ-035 FAST for 10 cycles then HALT -> 10 tick pulses, tick_o=0 from the cycle after the HALT state is entered, state_o=00.
REQ-036 tick_cnt_o preloaded via 65535 ticks in FAST -> next tick gives tick_cnt_o=0x0000.
REQ-037 Resetn pulsed low at cnt=3 in RUN with gpio_o=0x3C -> gpio_o=0, tick_cnt_o=0, state_o=00 immediately, no tick after release while mode_i=00.
